// File: rtl/seq_detect_fsm_if.sv
// Serial pattern detector bus: qualified bit stream in, match status out.
interface seq_detect_fsm_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    localparam int SW = $clog2(LEN + 1);

    logic             clear;
    logic             din_valid;
    logic             din;
    logic             match_mealy;
    logic             match_moore;
    logic [SW-1:0]    progress;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output clear, din_valid, din,
        input  match_mealy, match_moore, progress, match_count, count_sat
    );

    modport slave (
        input  clear, din_valid, din,
        output match_mealy, match_moore, progress, match_count, count_sat
    );
endinterface

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: KMP-style FSM over a compile-time pattern with a
// combinational Mealy match pulse, a registered Moore match level and a
// saturating match counter.
module seq_detect_fsm #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    seq_detect_fsm_if.slave bus
);
    localparam int SW = $clog2(LEN + 1);
    localparam int NT = 2 ** SW;

    // Longest j <= p+1 such that prefix(j) equals the tail of prefix(p) followed by b.
    function automatic int kmp_next(input int p, input int b);
        int   k;
        int   idx;
        bit   ok;
        logic sb;
        k = 0;
        if (p < LEN) begin
            for (int j = 1; j <= p + 1; j++) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    idx = p + 1 - j + i;
                    sb  = (idx == p) ? b[0] : PATTERN[LEN-1-idx];
                    if (PATTERN[LEN-1-i] != sb) ok = 1'b0;
                end
                if (ok) k = j;
            end
        end
        return k;
    endfunction

    // Length of the longest proper border (prefix that is also a suffix) of PATTERN.
    function automatic int border_len();
        int bl;
        bit ok;
        bl = 0;
        for (int j = 1; j < LEN; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (PATTERN[LEN-1-i] != PATTERN[j-1-i]) ok = 1'b0;
            if (ok) bl = j;
        end
        return bl;
    endfunction

    localparam int B = border_len();

    generate
        if (LEN < 2 || LEN > 16) begin : g_bad_len
            $error("seq_detect_fsm: LEN must be in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
            $error("seq_detect_fsm: CNT_W must be in 1..32");
        end
        if ($bits(bus.match_count) != CNT_W || $bits(bus.progress) != SW) begin : g_bad_if
            $error("seq_detect_fsm: interface parameters do not match the detector");
        end
    endgenerate

    typedef enum logic [SW-1:0] {
        S0   = '0,
        DONE = SW'(LEN)
    } state_t;

    // Transition table indexed by effective prefix and incoming bit; padded to a
    // power of two so the prefix register can index it directly.
    logic [SW-1:0] w_tab [NT][2];

    genvar gp, gb;
    generate
        for (gp = 0; gp < NT; gp++) begin : g_row
            for (gb = 0; gb < 2; gb++) begin : g_col
                localparam int K = kmp_next(gp, gb);
                assign w_tab[gp][gb] = SW'(K);
            end
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic [SW-1:0]    w_p;
    logic [SW-1:0]    w_k;
    logic             w_legal;
    logic             w_hit;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    // State register; asynchronous reset drops any partial match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S0;
        else       r_state <= w_next;
    end

    // Next-state and Mealy match: effective prefix, KMP step, clear/illegal handling.
    always_comb begin
        w_legal = (r_state <= DONE);
        w_p     = '0;
        if (r_state == DONE)
            w_p = OVERLAP ? SW'(B) : '0;
        else if (w_legal)
            w_p = r_state;
        w_k    = w_tab[w_p][bus.din];
        w_hit  = bus.din_valid & ~bus.clear & ~reset & w_legal & (w_k == SW'(LEN));
        w_next = r_state;
        if (bus.clear || !w_legal)
            w_next = S0;
        else if (bus.din_valid)
            w_next = state_t'(w_k);
    end

    // Saturating match counter; clear wins over a completing bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (bus.clear)
            r_cnt <= '0;
        else if (w_hit && !w_sat)
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.match_mealy = w_hit;
    assign bus.match_moore = (r_state == DONE);
    assign bus.progress    = r_state;
    assign bus.match_count = r_cnt;
    assign bus.count_sat   = w_sat;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm across four parameter sets.
module tb_seq_detect_fsm;
    logic       clk;
    logic       reset;
    logic       t_din;
    logic [3:0] t_vld;
    logic [3:0] t_clr;
    int         n_cmp;
    int         n_fail;

    seq_detect_fsm_if #(.LEN(4), .CNT_W(8)) if0 ();
    seq_detect_fsm_if #(.LEN(4), .CNT_W(8)) if1 ();
    seq_detect_fsm_if #(.LEN(4), .CNT_W(2)) if2 ();
    seq_detect_fsm_if #(.LEN(5), .CNT_W(8)) if3 ();

    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    seq_detect_fsm #(.LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8))
        u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if0.din = t_din; assign if0.din_valid = t_vld[0]; assign if0.clear = t_clr[0];
    assign if1.din = t_din; assign if1.din_valid = t_vld[1]; assign if1.clear = t_clr[1];
    assign if2.din = t_din; assign if2.din_valid = t_vld[2]; assign if2.clear = t_clr[2];
    assign if3.din = t_din; assign if3.din_valid = t_vld[3]; assign if3.clear = t_clr[3];

    logic [31:0] mo_mealy [4];
    logic [31:0] mo_moore [4];
    logic [31:0] mo_prog  [4];
    logic [31:0] mo_cnt   [4];
    logic [31:0] mo_sat   [4];

    assign mo_mealy[0] = 32'(if0.match_mealy); assign mo_moore[0] = 32'(if0.match_moore);
    assign mo_prog[0]  = 32'(if0.progress);    assign mo_cnt[0]   = 32'(if0.match_count);
    assign mo_sat[0]   = 32'(if0.count_sat);
    assign mo_mealy[1] = 32'(if1.match_mealy); assign mo_moore[1] = 32'(if1.match_moore);
    assign mo_prog[1]  = 32'(if1.progress);    assign mo_cnt[1]   = 32'(if1.match_count);
    assign mo_sat[1]   = 32'(if1.count_sat);
    assign mo_mealy[2] = 32'(if2.match_mealy); assign mo_moore[2] = 32'(if2.match_moore);
    assign mo_prog[2]  = 32'(if2.progress);    assign mo_cnt[2]   = 32'(if2.match_count);
    assign mo_sat[2]   = 32'(if2.count_sat);
    assign mo_mealy[3] = 32'(if3.match_mealy); assign mo_moore[3] = 32'(if3.match_moore);
    assign mo_prog[3]  = 32'(if3.progress);    assign mo_cnt[3]   = 32'(if3.match_count);
    assign mo_sat[3]   = 32'(if3.count_sat);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid bit into unit u; check Mealy before the edge, Moore/progress after.
    task automatic send(input int u, input logic d, input logic em, input int ep);
        @(negedge clk);
        t_din = d; t_vld = 4'(1 << u); t_clr = '0;
        #1;
        chk($sformatf("u%0d mealy", u), mo_mealy[u], 32'(em));
        @(posedge clk); #1;
        chk($sformatf("u%0d moore", u), mo_moore[u], 32'(em));
        chk($sformatf("u%0d progress", u), mo_prog[u], 32'(ep));
    endtask

    // Idle cycle (din_valid low) on unit u; state must hold.
    task automatic idle(input int u, input int ep, input logic emoore);
        @(negedge clk);
        t_din = 1'b1; t_vld = '0; t_clr = '0;
        #1;
        chk($sformatf("u%0d idle mealy", u), mo_mealy[u], 32'd0);
        @(posedge clk); #1;
        chk($sformatf("u%0d idle progress", u), mo_prog[u], 32'(ep));
        chk($sformatf("u%0d idle moore", u), mo_moore[u], 32'(emoore));
    endtask

    // Clear unit u, optionally together with a valid bit d.
    task automatic clr(input int u, input logic d, input logic v);
        @(negedge clk);
        t_din = d; t_vld = v ? 4'(1 << u) : 4'b0; t_clr = 4'(1 << u);
        #1;
        chk($sformatf("u%0d clear mealy", u), mo_mealy[u], 32'd0);
        @(posedge clk); #1;
        chk($sformatf("u%0d clear progress", u), mo_prog[u], 32'd0);
        chk($sformatf("u%0d clear count", u), mo_cnt[u], 32'd0);
        chk($sformatf("u%0d clear sat", u), mo_sat[u], 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        clk = 1'b0; reset = 1'b1;
        t_din = 1'b1; t_vld = 4'hF; t_clr = '0;
        #12;
        for (int u = 0; u < 4; u++) begin
            chk($sformatf("u%0d rst mealy", u), mo_mealy[u], 32'd0);
            chk($sformatf("u%0d rst moore", u), mo_moore[u], 32'd0);
            chk($sformatf("u%0d rst progress", u), mo_prog[u], 32'd0);
            chk($sformatf("u%0d rst count", u), mo_cnt[u], 32'd0);
            chk($sformatf("u%0d rst sat", u), mo_sat[u], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0; t_vld = '0;

        // Overlapping detection of 1011 in 1011011
        send(0, 1, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3); send(0, 1, 1, 4);
        send(0, 0, 0, 2); send(0, 1, 0, 3); send(0, 1, 1, 4);
        chk("u0 count two", mo_cnt[0], 32'd2);

        // Non-overlapping: 1011011 gives one match
        send(1, 1, 0, 1); send(1, 0, 0, 2); send(1, 1, 0, 3); send(1, 1, 1, 4);
        send(1, 0, 0, 0); send(1, 1, 0, 1); send(1, 1, 0, 1);
        chk("u1 count one", mo_cnt[1], 32'd1);
        // Non-overlapping: 10111011 gives matches at bits 3 and 7
        clr(1, 1'b0, 1'b0);
        send(1, 1, 0, 1); send(1, 0, 0, 2); send(1, 1, 0, 3); send(1, 1, 1, 4);
        send(1, 1, 0, 1); send(1, 0, 0, 2); send(1, 1, 0, 3); send(1, 1, 1, 4);
        chk("u1 count two", mo_cnt[1], 32'd2);

        // Gaps in din_valid hold progress; DONE persists across gaps
        clr(0, 1'b0, 1'b0);
        send(0, 1, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3);
        for (int i = 0; i < 5; i++) idle(0, 3, 1'b0);
        send(0, 1, 1, 4);
        chk("u0 gap count", mo_cnt[0], 32'd1);
        idle(0, 4, 1'b1); idle(0, 4, 1'b1);
        chk("u0 gap count hold", mo_cnt[0], 32'd1);

        // Counter saturation with CNT_W=2
        send(2, 1, 0, 1); send(2, 0, 0, 2); send(2, 1, 0, 3); send(2, 1, 1, 4);
        chk("u2 count 1", mo_cnt[2], 32'd1);
        for (int m = 2; m <= 5; m++) begin
            send(2, 0, 0, 2); send(2, 1, 0, 3); send(2, 1, 1, 4);
            chk($sformatf("u2 count after match %0d", m), mo_cnt[2], (m >= 3) ? 32'd3 : 32'(m));
        end
        chk("u2 sat", mo_sat[2], 32'd1);
        clr(2, 1'b0, 1'b0);

        // Asynchronous reset mid-pattern, with the completing bit on the bus
        clr(0, 1'b0, 1'b0);
        send(0, 1, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3);
        @(negedge clk);
        t_din = 1'b1; t_vld = 4'b0001; t_clr = '0;
        #2; reset = 1'b1; #1;
        chk("async rst progress", mo_prog[0], 32'd0);
        chk("async rst mealy", mo_mealy[0], 32'd0);
        @(posedge clk); #1;
        chk("async rst held progress", mo_prog[0], 32'd0);
        chk("async rst count", mo_cnt[0], 32'd0);
        @(negedge clk);
        reset = 1'b0; t_vld = '0;
        send(0, 1, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3); send(0, 1, 1, 4);
        chk("post rst count", mo_cnt[0], 32'd1);

        // Clear together with a completing bit
        clr(0, 1'b0, 1'b0);
        send(0, 1, 0, 1); send(0, 0, 0, 2); send(0, 1, 0, 3);
        clr(0, 1'b1, 1'b1);
        chk("clear+bit moore", mo_moore[0], 32'd0);

        // LEN=5, PATTERN=11011, border 2: 11011011 matches at bits 4 and 7
        send(3, 1, 0, 1); send(3, 1, 0, 2); send(3, 0, 0, 3); send(3, 1, 0, 4);
        send(3, 1, 1, 5); send(3, 0, 0, 3); send(3, 1, 0, 4); send(3, 1, 1, 5);
        chk("u3 count", mo_cnt[3], 32'd2);

        @(negedge clk);
        t_vld = '0; t_clr = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
